gsim_solver: RTL

Parametrised Gauss-Seidel solver for the banded Toeplitz system A·x = b. Row i of A has 20 on the diagonal, -13 at distance 1, 6 at distance 2 and -1 at distance 3. It generalises the fixed 16-unknown solver:

- the unknown count, input width and sweep limit are parameters;
- convergence is detected per sweep and a sweep-limit abort exists, with status reported;
- the result is drained through a ready/valid output port with backpressure.

It sits after the b-vector source and before the result consumer in the DSD exercise datapath.

---
 rtl/gsim_solver.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/gsim_solver.sv
// Gauss-Seidel solver for the banded Toeplitz system A*x = b.
// Row i of A: 20 on the diagonal, -13 at distance 1, 6 at distance 2, -1 at distance 3.
// Ports:
//   clk, reset      rising-edge clock, async active-high reset
//   in_en, b_in     b vector input, index order 0..N-1, accepted in LOAD
//   out_valid/ready result handshake; x_out is Q(BW) fixed point
//   out_last        flags the x[N-1] word
//   converged       status of the solve, valid while out_valid
//   iter_cnt        completed sweeps of the current solve
module gsim_solver #(
    parameter int N        = 16,
    parameter int BW       = 16,
    parameter int MAX_ITER = 100,
    parameter int IW       = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_en,
    input  logic signed [BW-1:0]   b_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [2*BW-1:0] x_out,
    output logic                   out_last,
    output logic                   converged,
    output logic [IW-1:0]          iter_cnt
);

    localparam int XW = 2 * BW;
    localparam int SW = 2 * BW + 6;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST = KW'(N - 1);
    localparam logic signed [SW-1:0] DIV = SW'(20);

    typedef enum logic [1:0] {
        LOAD,
        SOLVE,
        OUTPUT
    } state_t;

    state_t state, state_nxt;

    logic signed [BW-1:0] bm [N];
    logic signed [XW-1:0] x  [N];
    logic [KW-1:0]        idx;
    logic                 phase;
    logic                 changed;
    logic signed [SW-1:0] s_reg;
    logic signed [SW-1:0] s_comb;
    logic signed [SW-1:0] nb [1:3];
    logic signed [XW-1:0] x_new;
    logic                 last_idx;
    logic                 sweep_dirty;
    logic                 xfer;

    assign last_idx = (idx == LAST);
    assign xfer     = out_valid && out_ready;

    // Symmetric neighbour pairs; indices outside 0..N-1 are zero-filled.
    always_comb begin
        for (int d = 1; d <= 3; d++) begin
            nb[d] = '0;
            if (int'(idx) - d >= 0)
                nb[d] = nb[d] + SW'(x[KW'(int'(idx) - d)]);
            if (int'(idx) + d < N)
                nb[d] = nb[d] + SW'(x[KW'(int'(idx) + d)]);
        end
    end

    // 13*n1 - 6*n2 + n3 built from shifts to keep widths exact.
    always_comb begin
        s_comb = (SW'(bm[idx]) <<< BW)
               + (nb[1] <<< 3) + (nb[1] <<< 2) + nb[1]
               - ((nb[2] <<< 2) + (nb[2] <<< 1))
               + nb[3];
    end

    // Signed division truncates toward zero.
    assign x_new       = XW'(s_reg / DIV);
    assign sweep_dirty = changed || (x_new != x[idx]);

    assign out_valid = (state == OUTPUT);
    assign x_out     = out_valid ? x[idx] : '0;
    assign out_last  = out_valid && last_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD: begin
                if (in_en && last_idx)
                    state_nxt = SOLVE;
            end
            SOLVE: begin
                if (phase && last_idx &&
                    (!sweep_dirty || iter_cnt == IW'(MAX_ITER - 1)))
                    state_nxt = OUTPUT;
            end
            OUTPUT: begin
                if (xfer && last_idx)
                    state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            phase     <= 1'b0;
            changed   <= 1'b0;
            s_reg     <= '0;
            converged <= 1'b0;
            iter_cnt  <= '0;
            for (int k = 0; k < N; k++) begin
                x[k]  <= '0;
                bm[k] <= '0;
            end
        end else begin
            unique case (state)
                LOAD: begin
                    if (in_en) begin
                        bm[idx] <= b_in;
                        x[idx]  <= {b_in, {BW{1'b0}}};
                        if (last_idx) begin
                            idx       <= '0;
                            phase     <= 1'b0;
                            changed   <= 1'b0;
                            iter_cnt  <= '0;
                            converged <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                SOLVE: begin
                    if (!phase) begin
                        s_reg <= s_comb;
                        phase <= 1'b1;
                    end else begin
                        x[idx]  <= x_new;
                        phase   <= 1'b0;
                        changed <= sweep_dirty;
                        if (last_idx) begin
                            idx      <= '0;
                            changed  <= 1'b0;
                            iter_cnt <= iter_cnt + 1'b1;
                            if (!sweep_dirty)
                                converged <= 1'b1;
                            else if (iter_cnt == IW'(MAX_ITER - 1))
                                converged <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (xfer)
                        idx <= last_idx ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
